// File: rtl/ff_seq_ctrl_if.sv
// Host-side and flip-flop-side signals of the bit-serial flip-flop sequencer.
// The slave modport is the sequencer; the master is the host plus the flip-flop cell.
interface ff_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             ff_d;
    logic             ff_en;
    logic             ff_q;
    logic             ff_qb;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    err_cnt;
    logic             pass;
    logic             done;

    modport master (
        output start, din, ff_q, ff_qb,
        input  ff_d, ff_en, busy, dout, err_cnt, pass, done
    );

    modport slave (
        input  start, din, ff_q, ff_qb,
        output ff_d, ff_en, busy, dout, err_cnt, pass, done
    );
endinterface

// File: rtl/ff_seq_ctrl.sv
// Drives a latched word LSB-first into a single D flip-flop, one bit per DRIVE/SAMPLE
// slot, rebuilds the captured word from q and counts slots where q/qbar disagree.
module ff_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    ff_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FIN    = 2'd3;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [CW-1:0]    err_reg, err_next;
    logic             accept;
    logic             sampling;
    logic             bit_bad;

    assign accept   = (state_reg == ST_IDLE) && bus.start;
    assign sampling = (state_reg == ST_SAMPLE);
    // Both rails are checked: a healthy cell has q equal to the bit and qbar its inverse.
    assign bit_bad  = (bus.ff_q != sh_reg[0]) || (bus.ff_qb != ~sh_reg[0]);

    // Each dout bit clears on acceptance and is written only in its own sample slot.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dout
        assign dout_next[gi] = accept ? 1'b0 :
                               (sampling && idx_reg == IW'(gi)) ? bus.ff_q :
                               dout_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        sh_next    = sh_reg;
        idx_next   = idx_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    sh_next    = bus.din;
                    idx_next   = '0;
                    err_next   = '0;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bit_bad && err_reg != CNT_MAX) begin
                    err_next = err_reg + 1'b1;
                end
                sh_next    = {1'b0, sh_reg[WIDTH-1:1]};
                idx_next   = idx_reg + 1'b1;
                state_next = (idx_reg == IDX_LAST) ? ST_FIN : ST_DRIVE;
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sh_reg    <= '0;
            dout_reg  <= '0;
            idx_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sh_reg    <= sh_next;
            dout_reg  <= dout_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
        end
    end

    // All outputs decode registered state; sh is zero in IDLE once a word has drained.
    assign bus.ff_d    = sh_reg[0];
    assign bus.ff_en   = (state_reg == ST_DRIVE);
    assign bus.busy    = (state_reg != ST_IDLE);
    assign bus.done    = (state_reg == ST_FIN);
    assign bus.pass    = (state_reg == ST_FIN) && (err_reg == '0);
    assign bus.dout    = dout_reg;
    assign bus.err_cnt = err_reg;
endmodule

// File: tb/tb_ff_seq_ctrl.sv
// Bench for ff_seq_ctrl: a behavioural flip-flop cell with selectable faults, a vector
// table, randomized sequences against a per-bit reference, and multi-cycle corner cases.
module tb_ff_seq_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ff_mode = 0;   // 0 ideal, 1 q stuck-at-0, 2 qbar shorted to q, 3 q stuck-at-1
    logic cell_q = 1'b0;

    always #5 clk = ~clk;

    ff_seq_ctrl_if #(.WIDTH(W)) bus ();

    ff_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.ff_en) cell_q <= bus.ff_d;
    end

    always_comb begin
        bus.ff_q  = cell_q;
        bus.ff_qb = ~cell_q;
        case (ff_mode)
            1: bus.ff_q = 1'b0;
            2: bus.ff_qb = cell_q;
            3: bus.ff_q = 1'b1;
            default: ;
        endcase
    end

    typedef struct {
        logic [W-1:0] din;
        int           mode;
        logic [W-1:0] exp_dout;
        int           exp_err;
        logic         exp_pass;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: what the cell should return for each bit under a given fault.
    function automatic void ref_model(input logic [W-1:0] d, input int mode,
                                      output logic [W-1:0] rd, output int re);
        logic b, q, qb;
        rd = '0;
        re = 0;
        for (int i = 0; i < W; i++) begin
            b  = d[i];
            q  = b;
            qb = !b;
            if (mode == 1) q = 1'b0;
            if (mode == 2) qb = b;
            if (mode == 3) q = 1'b1;
            rd[i] = q;
            if (q != b || qb != !b) re++;
        end
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after FIN.
    task automatic run_seq(input string nm, input logic [W-1:0] d, input int mode,
                           input logic [W-1:0] exp_dout, input int exp_err, input logic exp_pass);
        int           cycles;
        int           en_cnt;
        logic         prev_en;
        logic [W-1:0] drv;
        ff_mode = mode;
        bus.din = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, " cleared_on_accept"}, {bus.dout, 4'(bus.err_cnt)}, '0);
        cycles = 1;
        en_cnt = 0;
        prev_en = 1'b0;
        drv = '0;
        while (!bus.done && cycles < 4 * W + 10) begin
            if (bus.ff_en) begin
                if (prev_en) chk({nm, " en_consecutive"}, 1, 0);
                if (en_cnt < W) drv[en_cnt] = bus.ff_d;
                en_cnt++;
            end
            if (!bus.busy) chk({nm, " busy_drop"}, 0, 1);
            prev_en = bus.ff_en;
            @(negedge clk);
            cycles++;
        end
        chk({nm, " done_cycle"}, cycles, 2 * W + 1);
        chk({nm, " en_count"}, en_cnt, W);
        chk({nm, " ff_d_bits"}, drv, d);
        chk({nm, " dout"}, bus.dout, exp_dout);
        chk({nm, " err_cnt"}, bus.err_cnt, exp_err);
        chk({nm, " pass"}, bus.pass, exp_pass);
        $display("seq %s din=%02h mode=%0d dout=%02h err=%0d pass=%0b cycles=%0d",
                 nm, d, mode, bus.dout, bus.err_cnt, bus.pass, cycles);
        @(negedge clk);
        chk({nm, " idle_flags"}, {bus.busy, bus.done, bus.pass, bus.ff_en}, 4'b0000);
        chk({nm, " dout_held"}, {bus.dout, 4'(bus.err_cnt)}, {exp_dout, 4'(exp_err)});
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] rdin;
        int           re;
        int           rmode;
        int           done_cnt;
        int           done_at[$];

        vecs[0] = '{8'hA5, 0, 8'hA5, 0, 1'b1};
        vecs[1] = '{8'hFF, 1, 8'h00, 8, 1'b0};
        vecs[2] = '{8'h0F, 2, 8'h0F, 8, 1'b0};
        vecs[3] = '{8'h00, 3, 8'hFF, 8, 1'b0};
        vecs[4] = '{8'h3C, 3, 8'hFF, 4, 1'b0};
        vecs[5] = '{8'hF0, 1, 8'h00, 4, 1'b0};

        bus.start = 1'b0;
        bus.din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.ff_d, bus.ff_en, bus.busy, bus.pass, bus.done},
            5'b00000);
        chk("reset_data", {bus.dout, 4'(bus.err_cnt)}, '0);

        // Table vectors run back-to-back: each start lands in the IDLE cycle after FIN.
        for (int v = 0; v < 6; v++) begin
            run_seq($sformatf("vec%0d", v), vecs[v].din, vecs[v].mode,
                    vecs[v].exp_dout, vecs[v].exp_err, vecs[v].exp_pass);
        end

        for (int r = 0; r < 20; r++) begin
            rdin = W'($urandom);
            rmode = int'($urandom_range(0, 3));
            ref_model(rdin, rmode, rd, re);
            run_seq($sformatf("rnd%0d", r), rdin, rmode, rd, re, re == 0);
        end

        // start held high 40 cycles; din scrambled while busy.
        ff_mode = 0;
        bus.din = 8'h3C;
        bus.start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                done_at.push_back(c);
                chk("hold_dout", bus.dout, 8'h3C);
                chk("hold_pass", bus.pass, 1'b1);
            end
            bus.din = bus.busy ? W'($urandom) : 8'h3C;
        end
        bus.start = 1'b0;
        chk("hold_done_count", done_cnt, 2);
        if (done_at.size() == 2) begin
            chk("hold_first_done", done_at[0], 17);
            chk("hold_second_done", done_at[1], 35);
        end
        for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
        chk("hold_drained", bus.busy, 1'b0);
        @(negedge clk);

        // Reset during the SAMPLE slot of bit 3.
        bus.din = 8'hC3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("rst_in_sample", {bus.busy, bus.ff_en}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {bus.ff_d, bus.ff_en, bus.busy, bus.pass, bus.done},
            5'b00000);
        chk("rst_mid_data", {bus.dout, 4'(bus.err_cnt)}, '0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("rst_no_activity", done_cnt, 0);
        run_seq("after_rst", 8'h81, 0, 8'h81, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ff_seq_ctrl.md
# ff_seq_ctrl

Sequencer that exercises a single D flip-flop cell (data input, clock enable, true and complement outputs) bit-serially. On `start` it latches a WIDTH-bit word and drives it into the flip-flop LSB first, one bit per two-cycle slot. It samples the flip-flop's q/qbar after each bit, rebuilds the captured word and counts per-bit mismatches. It sits between a test/host controller and the flip-flop cell, acting as that cell's sole owner and scheduler.

## Interface
- WIDTH, 8, bits per sequenced word (2..32)
- CW, $clog2(WIDTH+1), width of mismatch counter (derived, not overridden)

- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- start  in  1  request to sequence `din`; accepted only in IDLE
- din  in  WIDTH  word to drive; latched on accepted start
- ff_d  out  1  serial bit driven to the flip-flop D input
- ff_en  out  1  flip-flop clock enable; the flip-flop captures ff_d on the clk edge ending a cycle with ff_en=1
- ff_q  in  1  flip-flop true output
- ff_qb  in  1  flip-flop complement output
- busy  out  1  high whenever state is not IDLE
- dout  out  WIDTH  word rebuilt from sampled ff_q, bit i = sample of bit i
- err_cnt  out  CW  number of bit slots that failed the check
- pass  out  1  valid with done; 1 iff err_cnt==0
- done  out  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, DRIVE, SAMPLE, FIN.
- IDLE: ff_en=0, busy=0. On start=1, latch din into shift register sh, clear bit index idx=0, clear dout and err_cnt, then go to DRIVE.
- DRIVE: ff_d=sh[0], ff_en=1, then go to SAMPLE.
- SAMPLE: ff_en=0, ff_d holds sh[0]. Write dout[idx]=ff_q.
  - Mismatch when ff_q!=sh[0] or ff_qb!=~sh[0]. On mismatch, err_cnt+1 (saturating at WIDTH; cannot exceed WIDTH by construction).
  - Shift sh right by 1, idx+1.
  - If idx==WIDTH-1, go to FIN; else go to DRIVE.
- FIN: done=1, pass=(err_cnt==0) using the final count including the last slot, then go to IDLE.
- dout and err_cnt hold their values in IDLE until the next accepted start clears them.
- start while busy (DRIVE, SAMPLE, FIN) is ignored and not queued. start in the IDLE cycle right after FIN is accepted.
- ff_q/ff_qb are treated as synchronous to clk. No synchronizers.

## Timing
- Reset values: state=IDLE, ff_d=0, ff_en=0, busy=0, dout=0, err_cnt=0, pass=0, done=0, sh=0, idx=0.
- rst asserted in any state, including mid-sequence, returns the block to reset values on the next edge. No done pulse is produced and ff_en drops immediately on that edge.
- start sampled high in IDLE at edge E0:
  - busy=1 and first DRIVE from cycle E0+1.
  - Bit i: DRIVE in cycle E0+1+2i, SAMPLE in cycle E0+2+2i.
  - FIN (done=1) in cycle E0+1+2·WIDTH.
  - Back in IDLE from E0+2+2·WIDTH.
  - Total busy span is 2·WIDTH+1 cycles.
- ff_en is high exactly WIDTH cycles per sequence, never in two consecutive cycles.
- dout, err_cnt and pass are stable and final while done=1. pass is 0 outside the FIN cycle.
- Outputs are registered (state-decoded from registers). There is no combinational path from start, ff_q or ff_qb to any output.

## Test plan
- Ideal flip-flop model, WIDTH=8, din=8'hA5, start pulsed once → ff_d over the DRIVE cycles = 1,0,1,0,0,1,0,1; done exactly 17 cycles after the start edge; dout=8'hA5, err_cnt=0, pass=1.
- Flip-flop model with q stuck-at-0, din=8'hFF → dout=8'h00, err_cnt=8, pass=0; ff_en pulsed 8 times.
- Flip-flop model with qbar shorted to q (qb=q), din=8'h0F → dout=8'h0F, err_cnt=8, pass=0.
- start held high continuously for 40 cycles, din=8'h3C → exactly two sequences; second DRIVE begins the cycle after the first IDLE; each done 17 cycles apart plus 1 IDLE cycle; din changes during busy have no effect on dout.
- rst asserted in the SAMPLE slot of bit 3, din=8'hC3 → next cycle all outputs at reset values, no done; a subsequent start with din=8'h81 completes normally with dout=8'h81, pass=1.
- Back-to-back: start asserted in the first IDLE cycle after done → accepted; dout and err_cnt clear on acceptance, and the prior results remain readable during the intervening IDLE cycle.
